// File: rtl/slice_addsub_pkg.sv
// Shared types and helpers for the sliced add/subtract unit.
package slice_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/slice_addsub_adder.sv
// Combinational W-bit ripple adder made of full-adder cells; one instance serves every slice.
module slice_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_c[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout_c = c[W];

endmodule

// File: rtl/slice_addsub.sv
// Multi-cycle add/subtract processing SLICE bits per clock with a registered ripple carry.
// Optional SLICE_ADDSUB_CMP_EN adds lt/ltu compare outputs for SLT/SLTU/branches.
module slice_addsub
  import slice_addsub_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
`ifdef SLICE_ADDSUB_CMP_EN
  output logic         lt,
  output logic         ltu,
`endif
  output logic         zero
);

  localparam int unsigned NS = N / SLICE;
  localparam int unsigned IW = (NS > 1) ? clog2(NS) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    bx_q;
  logic [N-1:0]    sum_q;
  logic            cout_q;
  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic            c_sl;
  logic            accept, last, done;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (idx_q == IW'(NS - 1));
  assign done   = (state_q == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a_sl = a_q[idx_q*SLICE +: SLICE];
  assign b_sl = bx_q[idx_q*SLICE +: SLICE];

  slice_adder #(.W(SLICE)) u_adder (
    .a      (a_sl),
    .b      (b_sl),
    .cin    (carry_q),
    .sum_c  (s_sl),
    .cout_c (c_sl)
  );

  // Operand capture and per-slice accumulation; subtraction is A + ~B + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= sub;
      a_q     <= A;
      bx_q    <= B ^ {N{sub}};
    end else if (state_q == BUSY) begin
      sum_q[idx_q*SLICE +: SLICE] <= s_sl;
      carry_q <= c_sl;
      idx_q   <= IW'(idx_q + 1'b1);
      if (last) cout_q <= c_sl;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = done;
  assign sum       = sum_q;
  assign cout      = cout_q;
  // Flags are gated so they read 0 outside DONE, including under reset.
  assign ovf  = done && (a_q[N-1] == bx_q[N-1]) && (sum_q[N-1] != a_q[N-1]);
  assign zero = done && (sum_q == '0);

`ifdef SLICE_ADDSUB_CMP_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end

  assign lt  = done && sub_q && (sum_q[N-1] ^ ovf);
  assign ltu = done && sub_q && !cout_q;
`endif

endmodule

// File: tb/tb_slice_addsub.sv
// Directed self-checking bench for slice_addsub at N=32, SLICE=8.
module tb_slice_addsub;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [N-1:0] a, b, sum;
  logic         cout, ovf, zero;
`ifdef SLICE_ADDSUB_CMP_EN
  logic         lt, ltu;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slice_addsub #(.N(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
`ifdef SLICE_ADDSUB_CMP_EN
    .lt        (lt),
    .ltu       (ltu),
`endif
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency and flags, then consume the result.
  task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input logic s, input logic [31:0] esum, input logic ec,
                        input logic eo, input logic ez, input logic elt, input logic eltu);
    int cnt;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = opa; b = opb; sub = s;
    @(posedge clk);
    #1 in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (out_valid) break;
    end
    check({tag, ".latency"}, 32'(cnt), 32'd4);
    check({tag, ".sum"},  sum, esum);
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"},  32'(ovf),  32'(eo));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
`ifdef SLICE_ADDSUB_CMP_EN
    check({tag, ".lt"},  32'(lt),  32'(elt));
    check({tag, ".ltu"}, 32'(ltu), 32'(eltu));
`else
    if (elt || eltu) ; // compare outputs absent in this build
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.sum", sum, 32'd0);
    check("reset.zero", 32'(zero), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset.in_ready", 32'(in_ready), 32'd1);

    run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 0, 0, 0, 0, 0);
    run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 0, 0);
    run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1, 0, 0);
    run_op("sub_5_5",    32'd5,         32'd5,         1'b1, 32'h0000_0000, 1, 0, 1, 0, 0);
    run_op("sub_3_5",    32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);
    run_op("sub_min_1",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 1, 0);
    run_op("sub_10_3",   32'd10,        32'd3,         1'b1, 32'h0000_0007, 1, 0, 0, 0, 0);

    // Stall in DONE while new operands are offered.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
    @(posedge clk);
    #1 a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (out_valid) break;
    end
    check("hold.latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold.sum", sum, 32'h2345_6789);
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.in_ready", 32'(in_ready), 32'd0);
      check("hold.cout", 32'(cout), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 check("hold.in_ready_after", 32'(in_ready), 32'd1);
    check("hold.out_valid_after", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Abort mid-BUSY with reset.
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.sum", sum, 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    check("abort.ovf", 32'(ovf), 32'd0);
    check("abort.zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort.in_ready", 32'(in_ready), 32'd1);
    run_op("post_abort", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
